// File: rtl/rv_pkg.sv
// Shared fetch-side types and constants: FSM state encoding, reset PC default, NOP word.
package rv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

endpackage

// File: rtl/pc_reg.sv
// Program counter: async-reset register with redirect load (word aligned) and sequential increment.
module pc_reg
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] target,
  input  logic        inc,
  output logic [31:0] pc,
  output logic [31:0] pc_next
);

  // pc_next is exposed so the sequencer can present the new address in the same cycle pc updates.
  always_comb begin
    pc_next = pc;
    if (load)
      pc_next = target & ~32'h3;
    else if (inc)
      pc_next = pc + 32'(PC_STEP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request, redirect flush, halt drain,
// and a one-entry response buffer so a response arriving under stall is held, not lost.
module fetch_sequencer
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  input  logic        halt_req,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        halted
);

  fetch_state_t state;
  logic         flush_pending;
  logic         halt_pending;
  logic         buf_valid;
  logic [31:0]  buf_data;
  logic [31:0]  pc;
  logic [31:0]  pc_next;
  logic         redirect_eff;
  logic         rsp_hit;
  logic         held;
  logic         capture;
  logic [31:0]  rsp_data;

  // A parked response counts as "arrived", so flush/halt/capture treat both sources alike.
  always_comb begin
    redirect_eff = redirect_valid && !halt_req && (state != HALT);
    rsp_hit      = (state == WAIT) && (imem_rsp_valid || buf_valid);
    rsp_data     = buf_valid ? buf_data : imem_rsp_data;
    held         = instr_valid && stall;
    capture      = rsp_hit && !flush_pending && !halt_pending && !halt_req
                   && !redirect_eff && !held;
  end

  pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (redirect_eff),
    .target  (redirect_target),
    .inc     (capture),
    .pc      (pc),
    .pc_next (pc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      imem_req_valid <= 1'b0;
      imem_req_addr  <= RESET_PC;
      instr_valid    <= 1'b0;
      instr          <= INSTR_NOP;
      instr_pc       <= '0;
      flush_pending  <= 1'b0;
      halt_pending   <= 1'b0;
      buf_valid      <= 1'b0;
      buf_data       <= '0;
      halted         <= 1'b0;
    end else begin
      if (instr_valid && !stall)
        instr_valid <= 1'b0;
      if (halt_req || redirect_eff)
        instr_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (halt_req) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state          <= REQ;
            imem_req_valid <= 1'b1;
            imem_req_addr  <= pc_next;
          end
        end

        REQ: begin
          if (imem_req_ready) begin
            state          <= WAIT;
            imem_req_valid <= 1'b0;
            if (halt_req)
              halt_pending <= 1'b1;
            if (redirect_eff)
              flush_pending <= 1'b1;
          end else if (halt_req) begin
            state          <= HALT;
            imem_req_valid <= 1'b0;
            halted         <= 1'b1;
          end else if (redirect_eff) begin
            flush_pending <= 1'b1;
          end
        end

        WAIT: begin
          if (rsp_hit) begin
            if (halt_req || halt_pending) begin
              state         <= HALT;
              halted        <= 1'b1;
              halt_pending  <= 1'b0;
              flush_pending <= 1'b0;
              buf_valid     <= 1'b0;
            end else if (flush_pending || redirect_eff) begin
              state          <= REQ;
              imem_req_valid <= 1'b1;
              imem_req_addr  <= pc_next;
              flush_pending  <= 1'b0;
              buf_valid      <= 1'b0;
            end else if (held) begin
              if (!buf_valid) begin
                buf_valid <= 1'b1;
                buf_data  <= imem_rsp_data;
              end
            end else begin
              instr          <= rsp_data;
              instr_pc       <= pc;
              instr_valid    <= 1'b1;
              buf_valid      <= 1'b0;
              state          <= REQ;
              imem_req_valid <= 1'b1;
              imem_req_addr  <= pc_next;
            end
          end else begin
            if (halt_req)
              halt_pending <= 1'b1;
            if (redirect_eff)
              flush_pending <= 1'b1;
          end
        end

        HALT: begin
          imem_req_valid <= 1'b0;
          halted         <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a one-outstanding instruction memory model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic        halt_req;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        halted;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int unsigned pend_delay = 0;
  int unsigned rsp_delay = 0;
  int unsigned acc_count = 0;
  int unsigned acc_mark;

  fetch_sequencer #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall           (stall),
    .halt_req        (halt_req),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: note acceptance before the edge, then drive any due response after it.
  task automatic step();
    logic        acc;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (acc) begin
      acc_count++;
      pend       = 1'b1;
      pend_addr  = a;
      pend_delay = rsp_delay;
    end
    if (pend) begin
      if (pend_delay == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        pend           = 1'b0;
      end else begin
        pend_delay--;
      end
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
    check({tag, "_req_addr"}, imem_req_addr, 32'h0);
    check({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
    check({tag, "_instr"}, instr, 32'h0000_0013);
    check({tag, "_instr_pc"}, instr_pc, 32'h0);
    check({tag, "_halted"}, {31'b0, halted}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = '0;
    stall = 1'b0;
    halt_req = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;

    repeat (2) @(posedge clk);
    #1;
    check_reset("rst0");
    rst = 1'b0;

    // Sequential fetch, zero-latency ready, 1-cycle response.
    step();
    check("c1_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("c1_req_addr", imem_req_addr, 32'h0);
    step();
    check("c2_instr_valid", {31'b0, instr_valid}, 32'd0);
    step();
    check("c3_instr_valid", {31'b0, instr_valid}, 32'd1);
    check("c3_instr_pc", instr_pc, 32'h0);
    check("c3_instr", instr, mem_word(32'h0));
    check("c3_req_addr", imem_req_addr, 32'h4);
    step();
    check("c4_instr_valid", {31'b0, instr_valid}, 32'd0);
    step();
    check("c5_instr_pc", instr_pc, 32'h4);
    step();
    step();
    check("c7_instr_pc", instr_pc, 32'h8);
    check("c7_instr", instr, mem_word(32'h8));
    check("c7_req_addr", imem_req_addr, 32'hC);

    // Stall for 5 cycles while 0x8 is presented.
    stall = 1'b1;
    acc_mark = acc_count;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
      check("stall_pc", instr_pc, 32'h8);
      check("stall_instr", instr, mem_word(32'h8));
    end
    check("stall_accepts", acc_count, acc_mark + 1);
    stall = 1'b0;
    step();
    check("unstall_pc", instr_pc, 32'hC);
    check("unstall_instr", instr, mem_word(32'hC));
    check("unstall_valid", {31'b0, instr_valid}, 32'd1);
    check("unstall_req_addr", imem_req_addr, 32'h10);

    // Redirect to 0x103 while waiting on the 0x10 response.
    rsp_delay = 2;
    step();
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    step();
    check("rdw_wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
    step();
    check("rdw_req_addr", imem_req_addr, 32'h100);
    check("rdw_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("rdw_dropped", {31'b0, instr_valid}, 32'd0);
    rsp_delay = 0;
    step();
    step();
    check("rdw_instr_pc", instr_pc, 32'h100);
    check("rdw_instr", instr, mem_word(32'h100));

    // Redirect to 0x20 while 0x104 is held unaccepted.
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0020;
    step();
    redirect_valid = 1'b0;
    check("rdr1_addr_held", imem_req_addr, 32'h104);
    check("rdr1_instr_valid", {31'b0, instr_valid}, 32'd0);
    imem_req_ready = 1'b1;
    step();
    step();
    check("rdr1_new_addr", imem_req_addr, 32'h20);
    check("rdr1_dropped", {31'b0, instr_valid}, 32'd0);

    // Redirect to 0x200 while 0x20 is held unaccepted.
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    check("rdr2_addr_a", imem_req_addr, 32'h20);
    step();
    check("rdr2_addr_b", imem_req_addr, 32'h20);
    check("rdr2_valid_b", {31'b0, imem_req_valid}, 32'd1);
    imem_req_ready = 1'b1;
    step();
    check("rdr2_accepted", {31'b0, imem_req_valid}, 32'd0);
    step();
    check("rdr2_new_addr", imem_req_addr, 32'h200);
    check("rdr2_dropped", {31'b0, instr_valid}, 32'd0);
    step();
    step();
    check("rdr2_instr_pc", instr_pc, 32'h200);

    // Same-cycle halt and redirect while waiting on 0x204.
    rsp_delay = 1;
    step();
    halt_req = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0300;
    step();
    halt_req = 1'b0;
    redirect_valid = 1'b0;
    check("halt_draining", {31'b0, halted}, 32'd0);
    step();
    check("halt_halted", {31'b0, halted}, 32'd1);
    check("halt_instr_valid", {31'b0, instr_valid}, 32'd0);
    acc_mark = acc_count;
    for (int i = 0; i < 12; i++) begin
      step();
      check("halt_hold", {30'b0, halted, imem_req_valid}, 32'h2);
    end
    check("halt_accepts", acc_count, acc_mark);
    rsp_delay = 0;

    // Reset out of HALT, redirect in IDLE to the top word, wrap to 0.
    rst = 1'b1;
    #1;
    check_reset("rst1");
    rst = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    step();
    step();
    check("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    check("wrap_next_addr", imem_req_addr, 32'h0);

    // Reset while in WAIT with an instruction held; stale response arrives afterwards.
    stall = 1'b1;
    rsp_delay = 2;
    step();
    check("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset("rst2");
    stall = 1'b0;
    imem_req_ready = 1'b0;
    rsp_delay = 0;
    step();
    rst = 1'b0;
    step();
    step();
    check("stale_ignored", {31'b0, instr_valid}, 32'd0);
    check("stale_req_addr", imem_req_addr, 32'h0);
    check("stale_req_valid", {31'b0, imem_req_valid}, 32'd1);
    imem_req_ready = 1'b1;
    step();
    step();
    check("post_rst_valid", {31'b0, instr_valid}, 32'd1);
    check("post_rst_pc", instr_pc, 32'h0);
    check("post_rst_instr", instr, mem_word(32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
